// File: rtl/onehot_decoder.sv
// onehot_decoder: registered 3-bit symbol {d2,d1,d0} to 4-bit one-hot decoder with idle gap and saturating stats
// Ports: clk, rst_n (sync active-low); in_valid/in_ready/d0/d1/d2 symbol input;
//        y/y_valid/y_ready one-hot output; sym_cnt/null_cnt saturating statistics.
// Option: ONEHOT_DECODER_NULL_FWD_EN forwards null symbols as y = 0000.
module onehot_decoder #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             d0,
  input  logic             d1,
  input  logic             d2,
  output logic [3:0]       y,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [CNT_W-1:0] sym_cnt,
  output logic [CNT_W-1:0] null_cnt
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, OUT, GAP} state_t;
  state_t r_state;
  logic [GW-1:0] r_gap;
  logic w_in_xfer, w_out_xfer;
  assign in_ready = (r_state == IDLE);
  assign w_in_xfer = in_valid && in_ready;
  assign w_out_xfer = y_valid && y_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gap <= '0;
      y <= 4'b0000;
      y_valid <= 1'b0;
      sym_cnt <= '0;
      null_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_in_xfer) begin
          if (d2) begin
            y <= 4'b0001 << {d1, d0};
            y_valid <= 1'b1;
            r_state <= OUT;
          end else begin
            if (~&null_cnt) null_cnt <= null_cnt + 1'b1;
`ifdef ONEHOT_DECODER_NULL_FWD_EN
            y <= 4'b0000;
            y_valid <= 1'b1;
            r_state <= OUT;
`endif
          end
        end
        OUT: if (w_out_xfer) begin
          // only active symbols carry a nonzero word, so forwarded nulls are not counted
          if ((|y) && (~&sym_cnt)) sym_cnt <= sym_cnt + 1'b1;
          y <= 4'b0000;
          y_valid <= 1'b0;
          r_gap <= GAP_LOAD;
          r_state <= (GAP_CYCLES > 0) ? GAP : IDLE;
        end
        GAP: if (r_gap == '0) r_state <= IDLE; else r_gap <= r_gap - 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_onehot_decoder.sv
// tb_onehot_decoder: two decoder instances (gap 2 / 8-bit counters, gap 0 / 2-bit counters) against a cycle model
module tb_onehot_decoder;
  localparam int GAPS[2] = '{2, 0};
  localparam int MAXC[2] = '{255, 3};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n[2], in_valid[2], in_ready[2], d0[2], d1[2], d2[2], y_valid[2], y_ready[2];
  logic [3:0] y[2];
  logic [7:0] sym_a, null_a;
  logic [1:0] sym_b, null_b;
  int n_checks = 0, n_errors = 0, cyc = 0;
  int m_pend[2], m_wait[2], m_sym[2], m_null[2];
  logic [3:0] m_y[2];
  int acc_cyc;
  onehot_decoder #(.GAP_CYCLES(2), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .d0(d0[0]), .d1(d1[0]), .d2(d2[0]), .y(y[0]), .y_valid(y_valid[0]),
    .y_ready(y_ready[0]), .sym_cnt(sym_a), .null_cnt(null_a));
  onehot_decoder #(.GAP_CYCLES(0), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .d0(d0[1]), .d1(d1[1]), .d2(d2[1]), .y(y[1]), .y_valid(y_valid[1]),
    .y_ready(y_ready[1]), .sym_cnt(sym_b), .null_cnt(null_b));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic model(input int i);
    if (!rst_n[i]) begin
      m_pend[i] = 0; m_wait[i] = 0; m_sym[i] = 0; m_null[i] = 0; m_y[i] = 4'b0000;
    end else if (m_pend[i] != 0) begin
      if (y_ready[i]) begin
        if (m_y[i] != 4'b0000) m_sym[i] = (m_sym[i] < MAXC[i]) ? m_sym[i] + 1 : m_sym[i];
        m_pend[i] = 0;
        m_y[i] = 4'b0000;
        m_wait[i] = GAPS[i];
      end
    end else if (m_wait[i] > 0) begin
      m_wait[i]--;
    end else if (in_valid[i]) begin
      if (d2[i]) begin
        m_pend[i] = 1;
        m_y[i] = 4'(1 << (2 * int'(d1[i]) + int'(d0[i])));
      end else begin
        m_null[i] = (m_null[i] < MAXC[i]) ? m_null[i] + 1 : m_null[i];
`ifdef ONEHOT_DECODER_NULL_FWD_EN
        m_pend[i] = 1;
        m_y[i] = 4'b0000;
`endif
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    model(0);
    model(1);
    cyc++;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("in_ready%0d", i), 32'(in_ready[i]), 32'(m_pend[i] == 0 && m_wait[i] == 0));
      check($sformatf("y_valid%0d", i), 32'(y_valid[i]), 32'(m_pend[i] != 0));
      check($sformatf("y%0d", i), 32'(y[i]), 32'(m_y[i]));
      check($sformatf("sym_cnt%0d", i), (i == 0) ? 32'(sym_a) : 32'(sym_b), 32'(m_sym[i]));
      check($sformatf("null_cnt%0d", i), (i == 0) ? 32'(null_a) : 32'(null_b), 32'(m_null[i]));
    end
  endtask
  task automatic send(input int i, input logic [2:0] s);
    int k;
    in_valid[i] = 1'b1;
    {d2[i], d1[i], d0[i]} = s;
    k = 0;
    while (!in_ready[i] && k < 20) begin
      step();
      k++;
    end
    if (k == 20) check("send_timeout", 32'(in_ready[i]), 32'd1);
    acc_cyc = cyc;
    step();
    in_valid[i] = 1'b0;
  endtask
  initial begin
    int prev, n;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; in_valid[i] = 1'b0; d0[i] = 1'b0; d1[i] = 1'b0; d2[i] = 1'b0; y_ready[i] = 1'b1;
    end
    step();
    step();
    check("reset_y", 32'(y[0]), 32'd0);
    check("reset_in_ready", 32'(in_ready[0]), 32'd1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    step();
    prev = -1;
    for (int s = 4; s < 8; s++) begin
      send(0, 3'(s));
      check("y_after_accept", 32'(y[0]), 32'(4'b0001 << (s - 4)));
      if (prev >= 0) check("spacing", 32'(acc_cyc - prev), 32'd4);
      prev = acc_cyc;
    end
    repeat (4) step();
    check("sym4", 32'(sym_a), 32'd4);
    send(0, 3'b000);
    send(0, 3'b011);
    repeat (4) step();
    check("null2", 32'(null_a), 32'd2);
`ifndef ONEHOT_DECODER_NULL_FWD_EN
    check("sym_after_null", 32'(sym_a), 32'd4);
`endif
    y_ready[0] = 1'b0;
    send(0, 3'b110);
    repeat (5) begin
      step();
      check("bp_y", 32'(y[0]), 32'h4);
      check("bp_ready", 32'(in_ready[0]), 32'd0);
    end
    y_ready[0] = 1'b1;
    step();
    n = 0;
    while (!in_ready[0] && n < 10) begin
      n++;
      step();
    end
    check("gap_len", 32'(n), 32'd2);
    y_ready[0] = 1'b0;
    send(0, 3'b111);
    check("pre_rst_y", 32'(y[0]), 32'h8);
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    check("rst_y", 32'(y[0]), 32'd0);
    check("rst_sym", 32'(sym_a), 32'd0);
    y_ready[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(1, 3'(4 + k % 4));
      step();
      check("sat_sym", 32'(sym_b), 32'((k + 1 < 3) ? k + 1 : 3));
    end
    in_valid[1] = 1'b1;
    {d2[1], d1[1], d0[1]} = 3'b111;
    n = 0;
    repeat (10) begin
      if (in_ready[1]) n++;
      step();
    end
    in_valid[1] = 1'b0;
    check("stream_accepts", 32'(n), 32'd5);
    repeat (3000) begin
      for (int i = 0; i < 2; i++) begin
        rst_n[i] = ($urandom_range(99) != 0);
        in_valid[i] = $urandom_range(1);
        {d2[i], d1[i], d0[i]} = 3'($urandom_range(7));
        y_ready[i] = ($urandom_range(3) != 0);
      end
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
